dac_spi_rx: RTL and testbench
=============================

DAC_SPI_RX -- requirements
Module: dac_spi_rx

Interface
REQ-001 Parameter N_CHAN, default 8: number of modelled DAC channels.
REQ-002 Parameter W_DATA, default 16: DAC code width.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth on all serial and control inputs.
REQ-004 Port clk_in, input, 1: sole clock. One clock only; reset is synchronous and active-high.
REQ-005 Port rst_in, input, 1: synchronous, active-high reset.
REQ-006 Port sclk_in, input, 1: serial clock from the DAC8568 master.
REQ-007 Port nsync_in, input, 1: frame select, active low.
REQ-008 Port din_in, input, 1: serial data, MSB first.
REQ-009 Port nldac_in, input, 1: hardware load, active low, edge-sensitive.
REQ-010 Port nclr_in, input, 1: clear, active low, level-sensitive.
REQ-011 Ports dv_out (1), cmd_out (4), chan_out (4), data_out (W_DATA), feat_out (4), outputs: decoded-frame strobe and its fields.
REQ-012 Port frame_err_out, output, 1: one-cycle pulse on an aborted frame.
REQ-013 Port rd_chan_in, input, 3: channel select for readback.
REQ-014 Ports in_reg_out and dac_reg_out, outputs, W_DATA each: input register and DAC register of channel rd_chan_in, combinational read.

Function
REQ-015 All inputs on ports 6-10 SHALL pass through a SYNC_STAGES flop chain; all edge detection uses the synchronized copies.
REQ-016 FSM states are IDLE, SHIFT and HOLD.
REQ-017 IDLE->SHIFT on a synchronized nsync falling edge; bit counter cleared.
REQ-018 In SHIFT, each synchronized sclk falling edge SHALL shift din into a 32-bit register and increment the counter.
REQ-019 When the counter reaches 32, the FSM SHALL go to HOLD and pulse dv_out on the next cycle.
REQ-020 Field decode: bits[31:28] prefix, [27:24] cmd_out, [23:20] chan_out, [19:4] data_out, [3:0] feat_out.
REQ-021 A non-zero prefix SHALL still pulse dv_out and SHALL leave the registers unchanged.
REQ-022 In HOLD, further sclk edges are ignored; a nsync rise returns the FSM to IDLE.
REQ-023 A nsync rise in SHIFT with counter below 32 SHALL pulse frame_err_out, return to IDLE, emit no dv_out and change no register.
REQ-024 Commit actions, executed in the dv_out cycle:
- cmd 0000: write the input register.
- cmd 0001: copy the addressed input register to its DAC register.
- cmd 0010: write the input register, then copy all input registers to the DAC registers.
- cmd 0011: write the input register and its DAC register.
- cmd 0111: clear all registers to 0.
- any other cmd: no action.
REQ-025 Address 1111 with a write command SHALL target all channels.
REQ-026 An address of N_CHAN or above, other than 1111, SHALL be ignored.
REQ-027 A synchronized nldac falling edge SHALL copy all input registers to the DAC registers.
REQ-028 If an nldac falling edge and a commit occur in the same cycle, the copy SHALL use the newly written input values.
REQ-029 While synchronized nclr is low, all DAC registers SHALL be held at 0.
REQ-030 Clear SHALL take priority over every update in the same cycle; input registers are unaffected by clear.
REQ-031 Latency: dv_out rises SYNC_STAGES+2 clk_in cycles after the 32nd raw sclk falling edge.
REQ-032 sclk high and low phases SHALL each be at least SYNC_STAGES+1 clk_in cycles. Behaviour below this limit is undefined.

Reset
REQ-033 rst_in SHALL force: FSM to IDLE; counter, shift register and synchronizers to 0, except nsync, nldac and nclr synchronizers to 1; all registers to 0; dv_out, frame_err_out and all field outputs to 0.
REQ-034 Reset mid-frame SHALL discard the partial frame and emit no frame_err_out.

Structure
REQ-035 Command codes, field bit positions, the all-channels address 1111 and the frame length of 32 SHALL live in a shared dac8568_pkg with dac_controller.
REQ-036 One sub-module, sync_edge, SHALL provide the synchronizer and rise/fall strobes, instantiated once per input.

Verification
REQ-037 Frame 0x0030ABC0 -> dv_out=1, cmd=0000, chan=3, data=0x0ABC, feat=0; in_reg[3]=0x0ABC, dac_reg[3]=0.
REQ-038 Frame 0x031FFFF0 -> every in_reg and dac_reg=0xFFFF. Then nclr low 10 cycles -> dac_reg=0, in_reg=0xFFFF; nclr high, nldac falling -> dac_reg=0xFFFF.
REQ-039 nsync rises after 17 bits -> frame_err_out pulses once, no dv_out, all registers unchanged; a following full frame decodes correctly.
REQ-040 Frame 0x00501230 with nldac falling in the commit cycle -> dac_reg[5]=0x0123. Same case with nclr low -> dac_reg[5]=0.
REQ-041 40 sclk pulses in one nsync window -> exactly one dv_out, decoded from the first 32 bits. Frame 0x07000000 -> all registers 0.
REQ-042 rst_in asserted after bit 20 -> FSM IDLE, outputs 0, no frame_err_out; a subsequent frame decodes normally.

Source files
------------

// File: rtl/dac8568_pkg.sv
// dac8568_pkg
//   Shared definitions for the DAC8568 serial frame: frame length, field
//   bit positions, command codes and the broadcast address. Used by the
//   frame receiver and by the DAC controller on the other side of the link.
package dac8568_pkg;

  localparam int FRAME_BITS = 32;

  localparam int PREFIX_MSB = 31;
  localparam int PREFIX_LSB = 28;
  localparam int CMD_MSB    = 27;
  localparam int CMD_LSB    = 24;
  localparam int CHAN_MSB   = 23;
  localparam int CHAN_LSB   = 20;
  localparam int DATA_MSB   = 19;
  localparam int DATA_LSB   = 4;
  localparam int FEAT_MSB   = 3;
  localparam int FEAT_LSB   = 0;

  localparam logic [3:0] CMD_WRITE         = 4'b0000;
  localparam logic [3:0] CMD_UPDATE        = 4'b0001;
  localparam logic [3:0] CMD_WRITE_UPD_ALL = 4'b0010;
  localparam logic [3:0] CMD_WRITE_UPD     = 4'b0011;
  localparam logic [3:0] CMD_CLEAR         = 4'b0111;

  localparam logic [3:0] ADDR_ALL = 4'hF;

  typedef struct packed {
    logic [3:0]  prefix;
    logic [3:0]  cmd;
    logic [3:0]  chan;
    logic [15:0] data;
    logic [3:0]  feat;
  } frame_t;

  function automatic frame_t decode_frame(input logic [FRAME_BITS-1:0] w);
    frame_t f;
    f.prefix = w[PREFIX_MSB:PREFIX_LSB];
    f.cmd    = w[CMD_MSB:CMD_LSB];
    f.chan   = w[CHAN_MSB:CHAN_LSB];
    f.data   = w[DATA_MSB:DATA_LSB];
    f.feat   = w[FEAT_MSB:FEAT_LSB];
    return f;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge
//   Brings one asynchronous input into the clk_in domain through a STAGES
//   deep flop chain and derives one-cycle rise/fall strobes from the
//   synchronized copy.
//   clk_in   : system clock
//   rst_in   : synchronous active-high reset; chain and edge history load RST_VAL
//   d_in     : raw asynchronous input
//   q_out    : synchronized level
//   rise_out : one-cycle strobe on a synchronized 0->1 transition
//   fall_out : one-cycle strobe on a synchronized 1->0 transition
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic q_out,
  output logic rise_out,
  output logic fall_out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  always_comb begin
    sync_d = (sync_q << 1) | STAGES'(d_in);
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Strobes are combinational from the last stage so they line up with
  // the cycle in which the synchronized level first shows the new value.
  assign q_out    = sync_q[STAGES-1];
  assign rise_out = sync_q[STAGES-1] & ~prev_q;
  assign fall_out = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/dac_spi_rx.sv
// dac_spi_rx
//   Slave-side model of a DAC8568 serial interface. Receives 32-bit frames
//   (MSB first, sampled on sclk falling edges while nsync is low), decodes
//   them, and maintains per-channel input and DAC registers.
//
//   state | meaning
//   IDLE  | waiting for nsync to fall
//   SHIFT | collecting bits; abort if nsync rises before 32 bits
//   HOLD  | frame committed, ignoring sclk until nsync returns high
//
//   clk_in, rst_in           : clock, synchronous active-high reset
//   sclk_in, nsync_in, din_in: serial link from the master (asynchronous)
//   nldac_in                 : load strobe, falling edge copies input->DAC regs
//   nclr_in                  : clear, DAC regs held at 0 while low
//   dv_out + field outputs   : one-cycle strobe per completed frame, fields held
//   frame_err_out            : one-cycle strobe per aborted frame
//   rd_chan_in               : readback channel select
//   in_reg_out, dac_reg_out  : combinational readback of the selected channel
module dac_spi_rx
  import dac8568_pkg::*;
#(
  parameter int N_CHAN      = 8,
  parameter int W_DATA      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              sclk_in,
  input  logic              nsync_in,
  input  logic              din_in,
  input  logic              nldac_in,
  input  logic              nclr_in,
  output logic              dv_out,
  output logic [3:0]        cmd_out,
  output logic [3:0]        chan_out,
  output logic [W_DATA-1:0] data_out,
  output logic [3:0]        feat_out,
  output logic              frame_err_out,
  input  logic [2:0]        rd_chan_in,
  output logic [W_DATA-1:0] in_reg_out,
  output logic [W_DATA-1:0] dac_reg_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [5:0] CNT_FULL = 6'(FRAME_BITS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic nsync_lvl, nsync_rise, nsync_fall;
  logic din_lvl, din_rise, din_fall;
  logic nldac_lvl, nldac_rise, nldac_fall;
  logic nclr_lvl, nclr_rise, nclr_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(sclk_in),
    .q_out(sclk_lvl), .rise_out(sclk_rise), .fall_out(sclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nsync (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(nsync_in),
    .q_out(nsync_lvl), .rise_out(nsync_rise), .fall_out(nsync_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(din_in),
    .q_out(din_lvl), .rise_out(din_rise), .fall_out(din_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nldac (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(nldac_in),
    .q_out(nldac_lvl), .rise_out(nldac_rise), .fall_out(nldac_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nclr (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(nclr_in),
    .q_out(nclr_lvl), .rise_out(nclr_rise), .fall_out(nclr_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_lvl, sclk_rise, din_rise, din_fall,
                         nldac_lvl, nldac_rise, nclr_rise, nclr_fall};

  logic [1:0]            state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  dv_q, dv_d;
  logic                  err_q, err_d;
  logic                  commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (nsync_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      ST_SHIFT: begin
        // A full count wins over a simultaneous nsync rise: the frame is complete.
        if (cnt_q == CNT_FULL) begin
          commit  = 1'b1;
          dv_d    = 1'b1;
          state_d = ST_HOLD;
        end else if (nsync_rise) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (sclk_fall) begin
          shift_d = {shift_q[FRAME_BITS-2:0], din_lvl};
          cnt_d   = cnt_q + 6'd1;
        end
      end
      ST_HOLD: begin
        // Level test so an nsync rise that landed during the commit cycle
        // still releases the FSM.
        if (nsync_lvl) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  frame_t frame;
  assign frame = decode_frame(shift_q);

  logic [3:0]        cmd_q, cmd_d;
  logic [3:0]        chan_q, chan_d;
  logic [W_DATA-1:0] data_q, data_d;
  logic [3:0]        feat_q, feat_d;

  always_comb begin
    cmd_d  = cmd_q;
    chan_d = chan_q;
    data_d = data_q;
    feat_d = feat_q;
    if (commit) begin
      cmd_d  = frame.cmd;
      chan_d = frame.chan;
      data_d = W_DATA'(frame.data);
      feat_d = frame.feat;
    end
  end

  logic [W_DATA-1:0] in_reg_q  [N_CHAN];
  logic [W_DATA-1:0] in_reg_d  [N_CHAN];
  logic [W_DATA-1:0] dac_reg_q [N_CHAN];
  logic [W_DATA-1:0] dac_reg_d [N_CHAN];
  logic              addr_ok;
  logic              hit;
  logic [W_DATA-1:0] wdata;

  // Update order matters: frame commit first, then an nldac copy sees the
  // freshly written input registers, then clear overrides every DAC update.
  always_comb begin
    in_reg_d  = in_reg_q;
    dac_reg_d = dac_reg_q;
    hit       = 1'b0;
    wdata     = W_DATA'(frame.data);
    addr_ok   = (frame.chan == ADDR_ALL) || (int'(frame.chan) < N_CHAN);
    if (commit && (frame.prefix == 4'd0)) begin
      if (frame.cmd == CMD_CLEAR) begin
        for (int i = 0; i < N_CHAN; i++) begin
          in_reg_d[i]  = '0;
          dac_reg_d[i] = '0;
        end
      end else if (addr_ok) begin
        for (int i = 0; i < N_CHAN; i++) begin
          hit = (frame.chan == ADDR_ALL) || (int'(frame.chan) == i);
          if (hit) begin
            case (frame.cmd)
              CMD_WRITE, CMD_WRITE_UPD_ALL: in_reg_d[i] = wdata;
              CMD_UPDATE:                   dac_reg_d[i] = in_reg_q[i];
              CMD_WRITE_UPD: begin
                in_reg_d[i]  = wdata;
                dac_reg_d[i] = wdata;
              end
              default: ;
            endcase
          end
        end
        if (frame.cmd == CMD_WRITE_UPD_ALL) dac_reg_d = in_reg_d;
      end
    end
    if (nldac_fall) dac_reg_d = in_reg_d;
    if (!nclr_lvl) begin
      for (int i = 0; i < N_CHAN; i++) dac_reg_d[i] = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      cmd_q   <= '0;
      chan_q  <= '0;
      data_q  <= '0;
      feat_q  <= '0;
      for (int i = 0; i < N_CHAN; i++) begin
        in_reg_q[i]  <= '0;
        dac_reg_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      dv_q      <= dv_d;
      err_q     <= err_d;
      cmd_q     <= cmd_d;
      chan_q    <= chan_d;
      data_q    <= data_d;
      feat_q    <= feat_d;
      in_reg_q  <= in_reg_d;
      dac_reg_q <= dac_reg_d;
    end
  end

  assign dv_out        = dv_q;
  assign frame_err_out = err_q;
  assign cmd_out       = cmd_q;
  assign chan_out      = chan_q;
  assign data_out      = data_q;
  assign feat_out      = feat_q;

  assign in_reg_out  = (int'(rd_chan_in) < N_CHAN) ? in_reg_q[rd_chan_in]  : '0;
  assign dac_reg_out = (int'(rd_chan_in) < N_CHAN) ? dac_reg_q[rd_chan_in] : '0;

endmodule

// File: tb/tb_dac_spi_rx.sv
// Randomized scoreboard bench for dac_spi_rx. Stimulus drives serial frames
// and control pins and pushes the expected outcome (from a behavioural
// register model) into queues; an independent monitor pops and compares
// whenever the DUT strobes dv_out/frame_err_out, or when a register check
// has been requested.
module tb_dac_spi_rx;

  localparam int N_CHAN      = 8;
  localparam int W_DATA      = 16;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              sclk_in = 1'b1;
  logic              nsync_in = 1'b1;
  logic              din_in = 1'b0;
  logic              nldac_in = 1'b1;
  logic              nclr_in = 1'b1;
  logic [2:0]        rd_chan_in = 3'd0;
  logic              dv_out;
  logic [3:0]        cmd_out, chan_out, feat_out;
  logic [W_DATA-1:0] data_out;
  logic              frame_err_out;
  logic [W_DATA-1:0] in_reg_out, dac_reg_out;

  dac_spi_rx #(.N_CHAN(N_CHAN), .W_DATA(W_DATA), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sclk_in(sclk_in), .nsync_in(nsync_in),
    .din_in(din_in), .nldac_in(nldac_in), .nclr_in(nclr_in),
    .dv_out(dv_out), .cmd_out(cmd_out), .chan_out(chan_out), .data_out(data_out),
    .feat_out(feat_out), .frame_err_out(frame_err_out), .rd_chan_in(rd_chan_in),
    .in_reg_out(in_reg_out), .dac_reg_out(dac_reg_out)
  );

  always #10 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    bit                 is_err;
    logic [3:0]         cmd, chan, feat;
    logic [15:0]        data;
    int                 fall_cyc;
    logic [7:0][15:0]   in_s;
    logic [7:0][15:0]   dac_s;
  } ev_t;

  typedef struct {
    bit                 chk_fields;
    logic [7:0][15:0]   in_s;
    logic [7:0][15:0]   dac_s;
  } chk_t;

  ev_t  ev_q[$];
  chk_t chk_q[$];

  logic [7:0][15:0] in_m  = '0;
  logic [7:0][15:0] dac_m = '0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sweep(input logic [7:0][15:0] i_s, input logic [7:0][15:0] d_s);
    for (int c = 0; c < N_CHAN; c++) begin
      rd_chan_in = 3'(c);
      #1;
      check($sformatf("in_reg[%0d]", c), {16'd0, in_reg_out}, {16'd0, i_s[c]});
      check($sformatf("dac_reg[%0d]", c), {16'd0, dac_reg_out}, {16'd0, d_s[c]});
    end
  endtask

  // Monitor
  ev_t  cur;
  chk_t ck;
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (dv_out || frame_err_out) begin
        if (ev_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: dv=%0b err=%0b expected none", dv_out, frame_err_out);
        end else begin
          cur = ev_q.pop_front();
          check("event_kind_err", {31'd0, frame_err_out}, {31'd0, cur.is_err});
          if (!cur.is_err && dv_out) begin
            check("cmd_out", {28'd0, cmd_out}, {28'd0, cur.cmd});
            check("chan_out", {28'd0, chan_out}, {28'd0, cur.chan});
            check("data_out", {16'd0, data_out}, {16'd0, cur.data});
            check("feat_out", {28'd0, feat_out}, {28'd0, cur.feat});
            check("dv_latency", 32'(cyc - cur.fall_cyc), 32'(SYNC_STAGES + 2));
          end
          sweep(cur.in_s, cur.dac_s);
        end
      end else if (chk_q.size() != 0) begin
        ck = chk_q.pop_front();
        if (ck.chk_fields) begin
          check("rst_cmd_out", {28'd0, cmd_out}, 32'd0);
          check("rst_chan_out", {28'd0, chan_out}, 32'd0);
          check("rst_data_out", {16'd0, data_out}, 32'd0);
          check("rst_feat_out", {28'd0, feat_out}, 32'd0);
        end
        sweep(ck.in_s, ck.dac_s);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  task automatic push_check(input bit fields);
    chk_t c;
    c.chk_fields = fields;
    c.in_s       = in_m;
    c.dac_s      = dac_m;
    chk_q.push_back(c);
    wait_cyc(3);
  endtask

  // Behavioural register model: what a completed frame does to the registers.
  task automatic model_frame(input logic [31:0] w, input bit ldac);
    logic [3:0]  pre, cmd, ch;
    logic [15:0] d;
    pre = w[31:28];
    cmd = w[27:24];
    ch  = w[23:20];
    d   = w[19:4];
    if (pre == 4'd0) begin
      if (cmd == 4'b0111) begin
        in_m  = '0;
        dac_m = '0;
      end else if (cmd <= 4'd3 && (ch == 4'hF || int'(ch) < N_CHAN)) begin
        for (int c = 0; c < N_CHAN; c++) begin
          if (ch == 4'hF || int'(ch) == c) begin
            if (cmd == 4'd1) dac_m[c] = in_m[c];
            else in_m[c] = d;
            if (cmd == 4'd3) dac_m[c] = d;
          end
        end
        if (cmd == 4'd2) dac_m = in_m;
      end
    end
    if (ldac) dac_m = in_m;
    if (!nclr_in) dac_m = '0;
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits, input bit ldac);
    ev_t         e;
    logic [39:0] bits;
    bits = {word, 8'($urandom)};
    if (nbits >= 32) model_frame(word, ldac);
    e.is_err = (nbits < 32);
    e.cmd    = word[27:24];
    e.chan   = word[23:20];
    e.data   = word[19:4];
    e.feat   = word[3:0];
    e.fall_cyc = 0;
    e.in_s   = in_m;
    e.dac_s  = dac_m;
    nsync_in = 1'b0;
    wait_cyc(3);
    for (int i = 0; i < nbits; i++) begin
      din_in = bits[39-i];
      wait_cyc(HALF);
      sclk_in = 1'b0;
      if (i == 31) begin
        e.fall_cyc = cyc;
        ev_q.push_back(e);
        if (ldac) begin
          wait_cyc(1);
          nldac_in = 1'b0;
          wait_cyc(HALF - 1);
        end else begin
          wait_cyc(HALF);
        end
      end else begin
        wait_cyc(HALF);
      end
      sclk_in = 1'b1;
    end
    wait_cyc(HALF);
    nsync_in = 1'b1;
    if (nbits < 32) ev_q.push_back(e);
    wait_cyc(6);
    nldac_in = 1'b1;
    wait_cyc(4);
  endtask

  task automatic pulse_ldac();
    nldac_in = 1'b0;
    dac_m = nclr_in ? in_m : '0;
    wait_cyc(6);
    nldac_in = 1'b1;
    wait_cyc(2);
    push_check(1'b0);
  endtask

  task automatic set_nclr(input logic v, input int hold);
    nclr_in = v;
    if (!v) dac_m = '0;
    wait_cyc(hold);
    push_check(1'b0);
  endtask

  task automatic do_reset();
    rst_in   = 1'b1;
    sclk_in  = 1'b1;
    nsync_in = 1'b1;
    nldac_in = 1'b1;
    nclr_in  = 1'b1;
    wait_cyc(4);
    rst_in = 1'b0;
    in_m   = '0;
    dac_m  = '0;
    wait_cyc(2);
    push_check(1'b1);
  endtask

  task automatic partial_then_reset(input logic [31:0] word, input int nb);
    nsync_in = 1'b0;
    wait_cyc(3);
    for (int i = 0; i < nb; i++) begin
      din_in = word[31-i];
      wait_cyc(HALF);
      sclk_in = 1'b0;
      wait_cyc(HALF);
      sclk_in = 1'b1;
    end
    wait_cyc(2);
    do_reset();
  endtask

  logic [3:0] cmd_tab [6];
  logic [31:0] w;

  initial begin
    cmd_tab[0] = 4'h0; cmd_tab[1] = 4'h1; cmd_tab[2] = 4'h2;
    cmd_tab[3] = 4'h3; cmd_tab[4] = 4'h7; cmd_tab[5] = 4'h0;

    wait_cyc(1);
    do_reset();

    // Single-channel write
    send_frame(32'h0030ABC0, 32, 1'b0);
    // Broadcast write+update, then clear and reload
    send_frame(32'h031FFFF0, 32, 1'b0);
    set_nclr(1'b0, 10);
    set_nclr(1'b1, 6);
    pulse_ldac();
    // Aborted frame after 17 bits, then a clean frame
    send_frame(32'h00212340, 17, 1'b0);
    send_frame(32'h00212340, 32, 1'b0);
    // nldac coincident with commit, with and without clear
    send_frame(32'h00501230, 32, 1'b1);
    set_nclr(1'b0, 6);
    send_frame(32'h00501230, 32, 1'b1);
    set_nclr(1'b1, 6);
    // Over-long frame, nonzero prefix, out-of-range address, clear command
    send_frame(32'h03456780, 40, 1'b0);
    send_frame(32'h8030FFF0, 32, 1'b0);
    send_frame(32'h00A05550, 32, 1'b0);
    send_frame(32'h07000000, 32, 1'b0);
    // Reset mid-frame, then a normal frame
    send_frame(32'h031AAAA0, 32, 1'b0);
    partial_then_reset(32'h0061BEEF, 20);
    send_frame(32'h00611110, 32, 1'b0);

    for (int k = 0; k < 30; k++) begin
      w = $urandom;
      w[27:24] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : cmd_tab[$urandom_range(0, 5)];
      w[31:28] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      if ($urandom_range(0, 3) == 0) w[23:20] = 4'hF;
      send_frame(w, ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 31)) : 32,
                 ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 5) == 0) pulse_ldac();
    end

    wait_cyc(20);
    check("events_outstanding", 32'(ev_q.size()), 32'd0);
    check("checks_outstanding", 32'(chk_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
